ik_stage_sequencer: RTL
=======================

# ik_stage_sequencer

Parametrised sequencer for the SCARA inverse-kinematics pipeline. It accepts one (x, y) target per request and steps through NUM_STAGES arithmetic stages in order, one at a time, driving each stage's enable until that stage reports done. It captures the angle results from designated stages, forms th1 and th2, and presents them on a valid/ready output. A per-stage watchdog converts a hung stage into a reported error instead of a lockup. It sits between the target-command interface and the existing conversion, trig and arctan stages.

## Interface
Parameters:
- NUM_STAGES, 8: number of sequenced stages (≥3).
- ANGLE_W, 13: signed angle width.
- COORD_W, 14: unsigned target coordinate width.
- TIMEOUT, 1023: maximum cycles a stage enable may stay high without done (≥2).
- GAMMA_STAGE, 5: stage index whose angle is gamma.
- ATANXY_STAGE, 6: stage index whose angle is atan2(y, x).
- THETA2_STAGE, 7: stage index whose angle is th2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  target request valid.
- req_ready  out  1  sequencer idle, can accept a request.
- req_x, req_y  in  COORD_W  target coordinates.
- x_hold, y_hold  out  COORD_W  captured target, stable for the whole job.
- stage_en  out  NUM_STAGES  one-hot or zero enable to the stages.
- stage_done  in  NUM_STAGES  per-stage done.
- stage_angle  in  ANGLE_W  shared angle bus; sampled with done of an angle stage.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- th1, th2  out  ANGLE_W  signed joint angles.
- out_err  out  1  result is a timeout error.
- err_stage  out  $clog2(NUM_STAGES)  stage that timed out.

## Operation
- States: IDLE, RUN, GAP, OUT.
- IDLE:
  - req_ready=1.
  - When req_valid is high, capture req_x/req_y into x_hold/y_hold, set idx=0, clear out_err, go to RUN.
- RUN:
  - stage_en[idx]=1.
  - When stage_done[idx] is high:
    - If idx is an angle stage, capture stage_angle into its slot.
    - If idx==NUM_STAGES-1, go to OUT. Otherwise go to GAP.
  - If the watchdog reaches TIMEOUT consecutive enabled cycles without done: set out_err=1, set err_stage=idx, go to OUT.
  - If done and timeout occur in the same cycle, done wins.
- GAP:
  - All stage_en are 0 for exactly one cycle, so the downstream stage resets, since its reset is tied to ~en.
  - Then idx++ and go to RUN.
- OUT:
  - out_valid=1 and stage_en=0.
  - On a success transition into OUT:
    - th1 = (atanxy − gamma), truncated to ANGLE_W bits (two's-complement wrap).
    - th2 = theta2 slot.
  - On an error, th1/th2 keep their previous values.
  - When out_valid and out_ready are both high, go to IDLE.
- stage_done bits other than stage_done[idx], and any done while in GAP/IDLE/OUT, are ignored.
- Reset at any point: state=IDLE, with all outputs at reset values.

## Timing
- Reset values:
  - req_ready=1 (combinational from IDLE).
  - stage_en=0, out_valid=0, out_err=0, err_stage=0.
  - th1=0, th2=0, x_hold=0, y_hold=0.
- Request accepted at edge 0 means stage_en[0] is high from cycle 1.
- Stage with latency d (done high d cycles after its enable rises) occupies d+2 cycles including the GAP.
- Total latency with a uniform d: out_valid at cycle NUM_STAGES·(d+2). For N=8, d=1 this is cycle 24.
- Timeout: a stage enabled at cycle t with no done gives enable high for cycles t..t+TIMEOUT−1, and out_valid with out_err at t+TIMEOUT.
- Handshake in the same cycle out_valid rises: accepted, IDLE next cycle.
- req_ready is low during the handshake cycle, so a request arriving then waits one cycle.
- out_* are stable while out_valid=1 and out_ready=0.

## Structure
- Package ik_seq_pkg holds:
  - the state enum;
  - default stage-index constants;
  - the angle slot enum (GAMMA, ATANXY, THETA2).
- Sub-module stage_watchdog: counter of width $clog2(TIMEOUT+1).
  - Clears when enable is low.
  - Asserts expire at TIMEOUT.
  - Asynchronous reset.

## Test plan
- Nominal: N=8; stubs with d=1; gamma=100, atanxy=500, theta2=−200; request x=1200, y=3400 → out_valid at cycle 24, th1=400, th2=−200, out_err=0, x_hold=1200, y_hold=3400.
- Wrap: atanxy=4000, gamma=−300 → th1=−3892 (4300−8192); atanxy=−4000, gamma=300 → th1=3892.
- Timeout: TIMEOUT=16, stage 3 never done, others d=1 → stage_en[3] high cycles 10..25, out_valid=1 at 26 with out_err=1, err_stage=3, th1/th2 unchanged.
- Backpressure: out_ready low 5 cycles after out_valid → outputs stable, req_ready=0, a new req_valid is not accepted; out_ready high → IDLE next cycle, req accepted one cycle later.
- Spurious done: stage_done[6] pulsed while idx=2, and stage_done[2] pulsed during GAP → ignored; sequence and angles match nominal.
- Reset mid-op: reset asserted during stage 4 RUN → same cycle stage_en=0, out_valid=0, th1=th2=0; after release, a new request completes nominally.

Source files
------------

// File: rtl/ik_seq_pkg.sv
// Shared types and default stage indices for the SCARA IK stage sequencer.
package ik_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_OUT  = 2'd3
  } seq_state_e;

  localparam int DEF_NUM_STAGES   = 8;
  localparam int DEF_GAMMA_STAGE  = 5;
  localparam int DEF_ATANXY_STAGE = 6;
  localparam int DEF_THETA2_STAGE = 7;

  typedef enum logic [1:0] {
    SLOT_GAMMA  = 2'd0,
    SLOT_ATANXY = 2'd1,
    SLOT_THETA2 = 2'd2
  } angle_slot_e;

  localparam int NUM_SLOTS = 3;

endpackage

// File: rtl/ik_stage_sequencer_watchdog.sv
// Counts consecutive enabled cycles of one stage; expire_o flags the last allowed cycle.
module stage_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(TIMEOUT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is enabled cycle number cnt_q+1, so TIMEOUT is reached at cnt_q == TIMEOUT-1.
  assign expire_o = en_i && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ik_stage_sequencer.sv
// Steps the IK arithmetic stages one at a time, collects angle results and reports th1/th2 or a timeout.
module ik_stage_sequencer
  import ik_seq_pkg::*;
#(
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int ANGLE_W      = 13,
  parameter int COORD_W      = 14,
  parameter int TIMEOUT      = 1023,
  parameter int GAMMA_STAGE  = DEF_GAMMA_STAGE,
  parameter int ATANXY_STAGE = DEF_ATANXY_STAGE,
  parameter int THETA2_STAGE = DEF_THETA2_STAGE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [COORD_W-1:0]            req_x,
  input  logic [COORD_W-1:0]            req_y,
  output logic [COORD_W-1:0]            x_hold,
  output logic [COORD_W-1:0]            y_hold,
  output logic [NUM_STAGES-1:0]         stage_en,
  input  logic [NUM_STAGES-1:0]         stage_done,
  input  logic [ANGLE_W-1:0]            stage_angle,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ANGLE_W-1:0]            th1,
  output logic [ANGLE_W-1:0]            th2,
  output logic                          out_err,
  output logic [$clog2(NUM_STAGES)-1:0] err_stage
);

  localparam int IDX_W = $clog2(NUM_STAGES);

  seq_state_e                         state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [COORD_W-1:0]                 x_q, x_d, y_q, y_d;
  logic [NUM_SLOTS-1:0][ANGLE_W-1:0]  slot_q, slot_d;
  logic [ANGLE_W-1:0]                 th1_q, th1_d, th2_q, th2_d;
  logic                               err_q, err_d;
  logic [IDX_W-1:0]                   err_stage_q, err_stage_d;
  logic                               wd_en, wd_expire;

  assign wd_en = (state_q == ST_RUN);

  stage_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    x_d         = x_q;
    y_d         = y_q;
    slot_d      = slot_q;
    th1_d       = th1_q;
    th2_d       = th2_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A done from the active stage takes priority over a watchdog expiry in the same cycle.
        if (stage_done[idx_q]) begin
          if (idx_q == IDX_W'(GAMMA_STAGE))  slot_d[SLOT_GAMMA]  = stage_angle;
          if (idx_q == IDX_W'(ATANXY_STAGE)) slot_d[SLOT_ATANXY] = stage_angle;
          if (idx_q == IDX_W'(THETA2_STAGE)) slot_d[SLOT_THETA2] = stage_angle;
          if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
            th1_d   = slot_d[SLOT_ATANXY] - slot_d[SLOT_GAMMA];
            th2_d   = slot_d[SLOT_THETA2];
            state_d = ST_OUT;
          end else begin
            state_d = ST_GAP;
          end
        end else if (wd_expire) begin
          err_d       = 1'b1;
          err_stage_d = idx_q;
          state_d     = ST_OUT;
        end
      end
      ST_GAP: begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = ST_RUN;
      end
      ST_OUT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      slot_q      <= '0;
      th1_q       <= '0;
      th2_q       <= '0;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      x_q         <= x_d;
      y_q         <= y_d;
      slot_q      <= slot_d;
      th1_q       <= th1_d;
      th2_q       <= th2_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  // Enables drop in GAP so a stage whose reset is tied to ~en restarts cleanly.
  always_comb begin
    stage_en = '0;
    if (state_q == ST_RUN) stage_en[idx_q] = 1'b1;
  end

  assign req_ready = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign x_hold    = x_q;
  assign y_hold    = y_q;
  assign th1       = th1_q;
  assign th2       = th2_q;
  assign out_err   = err_q;
  assign err_stage = err_stage_q;

endmodule
